// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the pipeline MEM stage, the debug/dump port, the
// data memory and the arbiter. The arbiter takes the slave view; whatever
// drives the requesters and models the memory takes the master view.
interface dmem_arbiter_if #(parameter int ADDR_W = 9);
   logic              cpu_req;
   logic              cpu_we;
   logic [1:0]        cpu_size;
   logic [ADDR_W-1:0] cpu_addr;
   logic [31:0]       cpu_wdata;
   logic              cpu_stall;
   logic [31:0]       cpu_rdata;
   logic              cpu_rvalid;
   logic              cpu_err;

   logic              dbg_req;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [31:0]       dbg_wdata;
   logic              dbg_gnt;
   logic [31:0]       dbg_rdata;
   logic              dbg_rvalid;

   logic              mem_en;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
      output cpu_stall, cpu_rdata, cpu_rvalid, cpu_err,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_gnt, dbg_rdata, dbg_rvalid,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
      input  cpu_stall, cpu_rdata, cpu_rvalid, cpu_err,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_gnt, dbg_rdata, dbg_rvalid,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: MEM-stage loads/stores versus a word-wide
// debug port. One access per cycle, big-endian lane steering on stores and
// lane select plus zero-extension on loads. Debug is starvation-bounded.
module dmem_arbiter #(
   parameter int ADDR_W     = 9,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          reset,
   dmem_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0]  starve_cnt;
   logic              rd_valid;
   logic              rd_owner;   // 1 = debug read
   logic [1:0]        rd_size;
   logic [1:0]        rd_off;
   logic              cpu_err_q;

   logic              misalign;
   logic              dbg_win;
   logic              dbg_gnt;
   logic              cpu_gnt;
   logic              cpu_acc;
   logic [3:0]        cpu_be;
   logic [31:0]       cpu_wd;
   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       lane;

   // Alignment check on the CPU request
   always_comb begin
      misalign = 1'b0;
      case (bus.cpu_size)
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = bus.cpu_addr[0];
         default: misalign = (bus.cpu_addr[1:0] != 2'b00);
      endcase
   end

   // Arbitration; nothing is granted while reset is held
   always_comb begin
      dbg_win = bus.dbg_req & (~bus.cpu_req | (starve_cnt == CNT_W'(STARVE_MAX)));
      dbg_gnt = reset & dbg_win;
      cpu_gnt = reset & bus.cpu_req & ~dbg_win;
      cpu_acc = cpu_gnt & ~misalign;
   end

   // Big-endian store steering for CPU accesses
   always_comb begin
      cpu_be = 4'b1111;
      cpu_wd = bus.cpu_wdata;
      case (bus.cpu_size)
         2'b00: begin
            cpu_be = 4'b1000 >> bus.cpu_addr[1:0];
            cpu_wd = {4{bus.cpu_wdata[7:0]}};
         end
         2'b01: begin
            cpu_be = bus.cpu_addr[1] ? 4'b0011 : 4'b1100;
            cpu_wd = {2{bus.cpu_wdata[15:0]}};
         end
         default: begin
            cpu_be = 4'b1111;
            cpu_wd = bus.cpu_wdata;
         end
      endcase
   end

   // Memory strobe mux; all memory outputs idle at zero
   always_comb begin
      sel_addr = dbg_gnt ? bus.dbg_addr : bus.cpu_addr;
      bus.mem_en    = dbg_gnt | cpu_acc;
      bus.mem_we    = dbg_gnt ? bus.dbg_we : (cpu_acc & bus.cpu_we);
      bus.mem_be    = dbg_gnt ? 4'b1111 : (cpu_acc ? cpu_be : 4'b0000);
      bus.mem_addr  = bus.mem_en ? (sel_addr & ~ADDR_W'(3)) : '0;
      bus.mem_wdata = dbg_gnt ? bus.dbg_wdata : (cpu_acc ? cpu_wd : 32'h0);
   end

   // Starvation counter, read tag and misalignment error flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
         rd_valid   <= 1'b0;
         rd_owner   <= 1'b0;
         rd_size    <= 2'b00;
         rd_off     <= 2'b00;
         cpu_err_q  <= 1'b0;
      end else begin
         if (!bus.dbg_req || dbg_gnt)
            starve_cnt <= '0;
         else if (starve_cnt != CNT_W'(STARVE_MAX))
            starve_cnt <= starve_cnt + 1'b1;
         rd_valid  <= bus.mem_en & ~bus.mem_we;
         cpu_err_q <= cpu_gnt & misalign;
         if (bus.mem_en && !bus.mem_we) begin
            rd_owner <= dbg_gnt;
            rd_size  <= bus.cpu_size;
            rd_off   <= bus.cpu_addr[1:0];
         end
      end
   end

   // Load lane select and zero-extension for the CPU
   always_comb begin
      lane = bus.mem_rdata;
      case (rd_size)
         2'b00: begin
            case (rd_off)
               2'b00:   lane = {24'h0, bus.mem_rdata[31:24]};
               2'b01:   lane = {24'h0, bus.mem_rdata[23:16]};
               2'b10:   lane = {24'h0, bus.mem_rdata[15:8]};
               default: lane = {24'h0, bus.mem_rdata[7:0]};
            endcase
         end
         2'b01:   lane = rd_off[1] ? {16'h0, bus.mem_rdata[15:0]} : {16'h0, bus.mem_rdata[31:16]};
         default: lane = bus.mem_rdata;
      endcase
   end

   // Requester-facing outputs
   always_comb begin
      bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
      bus.cpu_rvalid = rd_valid & ~rd_owner;
      bus.cpu_rdata  = bus.cpu_rvalid ? lane : 32'h0;
      bus.cpu_err    = cpu_err_q;
      bus.dbg_gnt    = dbg_gnt;
      bus.dbg_rvalid = rd_valid & rd_owner;
      bus.dbg_rdata  = bus.dbg_rvalid ? bus.mem_rdata : 32'h0;
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, stores, loads, contention,
// misalignment and reset during an outstanding read.
module tb_dmem_arbiter;
   logic clk;
   logic reset;
   int   nvec;
   int   nerr;

   dmem_arbiter_if #(.ADDR_W(9)) bus ();

   dmem_arbiter #(.ADDR_W(9), .STARVE_MAX(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_size  = 2'b10;
      bus.cpu_addr  = 9'h000;
      bus.cpu_wdata = 32'h0;
      bus.dbg_req   = 1'b0;
      bus.dbg_we    = 1'b0;
      bus.dbg_addr  = 9'h000;
      bus.dbg_wdata = 32'h0;
      bus.mem_rdata = 32'h0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset        = 1'b0;
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 9'h010;
      bus.dbg_req  = 1'b1;
      cyc();
      cyc();
      #1;
      nvec++; if (bus.mem_en !== 1'b0) begin nerr++; $display("FAIL rst_mem_en: got %b want 0", bus.mem_en); end
      nvec++; if (bus.cpu_stall !== 1'b1) begin nerr++; $display("FAIL rst_cpu_stall: got %b want 1", bus.cpu_stall); end
      nvec++; if ({bus.cpu_rvalid, bus.cpu_err, bus.dbg_gnt, bus.dbg_rvalid} !== 4'b0000) begin nerr++; $display("FAIL rst_flags: got %b want 0000", {bus.cpu_rvalid, bus.cpu_err, bus.dbg_gnt, bus.dbg_rvalid}); end
      nvec++; if ({bus.cpu_rdata, bus.dbg_rdata, bus.mem_wdata} !== 96'h0) begin nerr++; $display("FAIL rst_data: got %h want 0", {bus.cpu_rdata, bus.dbg_rdata, bus.mem_wdata}); end
      cyc();
      reset       = 1'b1;
      bus.dbg_req = 1'b0;
      #1;
      nvec++; if (bus.cpu_stall !== 1'b0 || bus.mem_en !== 1'b1) begin nerr++; $display("FAIL rel_grant: stall %b en %b want 0 1", bus.cpu_stall, bus.mem_en); end
      nvec++; if (bus.mem_addr !== 9'h010) begin nerr++; $display("FAIL rel_addr: got %h want 010", bus.mem_addr); end
      cyc();
      idle_inputs();
   endtask

   task automatic test_stores();
      cyc();
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_size = 2'b00;
      bus.cpu_addr = 9'h005; bus.cpu_wdata = 32'h000000A5;
      #1;
      nvec++; if (bus.mem_addr !== 9'h004) begin nerr++; $display("FAIL stb_addr: got %h want 004", bus.mem_addr); end
      nvec++; if (bus.mem_be !== 4'b0100) begin nerr++; $display("FAIL stb_be: got %b want 0100", bus.mem_be); end
      nvec++; if (bus.mem_wdata !== 32'hA5A5A5A5) begin nerr++; $display("FAIL stb_wdata: got %h want a5a5a5a5", bus.mem_wdata); end
      nvec++; if ({bus.cpu_stall, bus.mem_en, bus.mem_we} !== 3'b011) begin nerr++; $display("FAIL stb_ctl: got %b want 011", {bus.cpu_stall, bus.mem_en, bus.mem_we}); end
      cyc();
      bus.cpu_size = 2'b01; bus.cpu_addr = 9'h002; bus.cpu_wdata = 32'h1234BEEF;
      #1;
      nvec++; if ({bus.mem_be, bus.mem_wdata} !== {4'b0011, 32'hBEEFBEEF}) begin nerr++; $display("FAIL sth_lane: got %b %h want 0011 beefbeef", bus.mem_be, bus.mem_wdata); end
      cyc();
      bus.cpu_size = 2'b11; bus.cpu_addr = 9'h1FC; bus.cpu_wdata = 32'hDEADBEEF;
      #1;
      nvec++; if ({bus.mem_be, bus.mem_wdata, bus.mem_addr} !== {4'b1111, 32'hDEADBEEF, 9'h1FC}) begin nerr++; $display("FAIL stw_lane: got %b %h %h want 1111 deadbeef 1fc", bus.mem_be, bus.mem_wdata, bus.mem_addr); end
      cyc();
      idle_inputs();
      bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 9'h0A7; bus.dbg_wdata = 32'h01020304;
      #1;
      nvec++; if ({bus.dbg_gnt, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== {2'b11, 4'b1111, 9'h0A4, 32'h01020304}) begin nerr++; $display("FAIL dbg_write: got %b %b %b %h %h", bus.dbg_gnt, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata); end
      cyc();
      idle_inputs();
      #1;
      nvec++; if ({bus.cpu_rvalid, bus.dbg_rvalid} !== 2'b00) begin nerr++; $display("FAIL write_noresp: got %b want 00", {bus.cpu_rvalid, bus.dbg_rvalid}); end
   endtask

   task automatic test_back_to_back_loads();
      cyc();
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_size = 2'b01; bus.cpu_addr = 9'h006;
      #1;
      nvec++; if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {2'b10, 9'h004}) begin nerr++; $display("FAIL ldh_issue: got %b %b %h want 1 0 004", bus.mem_en, bus.mem_we, bus.mem_addr); end
      cyc();
      bus.cpu_size = 2'b00; bus.cpu_addr = 9'h001;
      bus.mem_rdata = 32'h11223344;
      #1;
      nvec++; if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b1, 32'h00003344}) begin nerr++; $display("FAIL ldh_data: got %b %h want 1 00003344", bus.cpu_rvalid, bus.cpu_rdata); end
      cyc();
      bus.cpu_req = 1'b0;
      bus.mem_rdata = 32'h11223344;
      #1;
      nvec++; if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b1, 32'h00000022}) begin nerr++; $display("FAIL ldb_data: got %b %h want 1 00000022", bus.cpu_rvalid, bus.cpu_rdata); end
      cyc();
      #1;
      nvec++; if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b0, 32'h0}) begin nerr++; $display("FAIL ld_idle: got %b %h want 0 0", bus.cpu_rvalid, bus.cpu_rdata); end
      idle_inputs();
   endtask

   task automatic test_contention();
      cyc();
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_size = 2'b10; bus.cpu_addr = 9'h100;
      bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 9'h013;
      for (int i = 0; i < 4; i++) begin
         #1;
         nvec++; if ({bus.cpu_stall, bus.dbg_gnt, bus.mem_addr} !== {2'b00, 9'h100}) begin nerr++; $display("FAIL cont_cpu%0d: got %b %b %h want 0 0 100", i, bus.cpu_stall, bus.dbg_gnt, bus.mem_addr); end
         cyc();
      end
      #1;
      nvec++; if ({bus.dbg_gnt, bus.cpu_stall, bus.mem_en, bus.mem_addr} !== {3'b111, 9'h010}) begin nerr++; $display("FAIL cont_dbg: got %b %b %b %h want 1 1 1 010", bus.dbg_gnt, bus.cpu_stall, bus.mem_en, bus.mem_addr); end
      cyc();
      bus.dbg_req = 1'b0;
      bus.mem_rdata = 32'hCAFEF00D;
      #1;
      nvec++; if ({bus.dbg_rvalid, bus.dbg_rdata} !== {1'b1, 32'hCAFEF00D}) begin nerr++; $display("FAIL cont_dbg_rd: got %b %h want 1 cafef00d", bus.dbg_rvalid, bus.dbg_rdata); end
      nvec++; if ({bus.cpu_stall, bus.mem_en, bus.cpu_rvalid, bus.cpu_rdata} !== {3'b010, 32'h0}) begin nerr++; $display("FAIL cont_cpu_back: got %b %b %b %h want 0 1 0 0", bus.cpu_stall, bus.mem_en, bus.cpu_rvalid, bus.cpu_rdata); end
      cyc();
      idle_inputs();
      bus.dbg_req = 1'b1; bus.cpu_req = 1'b1; bus.cpu_addr = 9'h100;
      #1;
      nvec++; if ({bus.cpu_stall, bus.dbg_gnt} !== 2'b00) begin nerr++; $display("FAIL cont_cnt_clear: got %b %b want 0 0", bus.cpu_stall, bus.dbg_gnt); end
      cyc();
      idle_inputs();
   endtask

   task automatic test_misaligned();
      cyc();
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_size = 2'b10; bus.cpu_addr = 9'h002;
      #1;
      nvec++; if ({bus.mem_en, bus.cpu_stall} !== 2'b00) begin nerr++; $display("FAIL mis_issue: got %b %b want 0 0", bus.mem_en, bus.cpu_stall); end
      cyc();
      bus.cpu_req = 1'b0;
      #1;
      nvec++; if ({bus.cpu_err, bus.cpu_rvalid} !== 2'b10) begin nerr++; $display("FAIL mis_err: got %b %b want 1 0", bus.cpu_err, bus.cpu_rvalid); end
      cyc();
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_size = 2'b01; bus.cpu_addr = 9'h003;
      #1;
      nvec++; if ({bus.cpu_err, bus.mem_en, bus.cpu_stall} !== 3'b000) begin nerr++; $display("FAIL mis_sth: got %b %b %b want 0 0 0", bus.cpu_err, bus.mem_en, bus.cpu_stall); end
      cyc();
      idle_inputs();
      #1;
      nvec++; if (bus.cpu_err !== 1'b1) begin nerr++; $display("FAIL mis_sth_err: got %b want 1", bus.cpu_err); end
   endtask

   task automatic test_reset_mid_read();
      cyc();
      bus.cpu_req = 1'b1; bus.cpu_size = 2'b10; bus.cpu_addr = 9'h008;
      cyc();
      bus.cpu_req = 1'b0;
      bus.mem_rdata = 32'h55AA55AA;
      #1;
      nvec++; if (bus.cpu_rvalid !== 1'b1) begin nerr++; $display("FAIL mid_pre: got %b want 1", bus.cpu_rvalid); end
      reset = 1'b0;
      #1;
      nvec++; if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b0, 32'h0}) begin nerr++; $display("FAIL mid_drop: got %b %h want 0 0", bus.cpu_rvalid, bus.cpu_rdata); end
      cyc();
      reset = 1'b1;
      #1;
      nvec++; if (bus.cpu_rvalid !== 1'b0) begin nerr++; $display("FAIL mid_release: got %b want 0", bus.cpu_rvalid); end
      cyc();
      #1;
      nvec++; if (bus.cpu_rvalid !== 1'b0) begin nerr++; $display("FAIL mid_after: got %b want 0", bus.cpu_rvalid); end
      bus.cpu_req = 1'b1; bus.cpu_size = 2'b01; bus.cpu_addr = 9'h003;
      cyc();
      bus.cpu_req = 1'b0;
      reset = 1'b0;
      #1;
      nvec++; if (bus.cpu_err !== 1'b0) begin nerr++; $display("FAIL err_drop: got %b want 0", bus.cpu_err); end
      cyc();
      reset = 1'b1;
      #1;
      nvec++; if (bus.cpu_err !== 1'b0) begin nerr++; $display("FAIL err_after: got %b want 0", bus.cpu_err); end
      idle_inputs();
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      reset = 1'b0;
      idle_inputs();
      test_reset();
      test_stores();
      test_back_to_back_loads();
      test_contention();
      test_misaligned();
      test_reset_mid_read();
      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
